// File: rtl/spi_reg_pkg.sv
// Shared constants, register map and FSM state type for the SPI register-frame controller.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam logic        RW_WRITE   = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_EN_REG_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_REG_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_REG_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_REG_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY_CYCLE  = 7'h04;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV enabled cycles, restarted by clear.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator issuing 16-bit {rw, addr, data} register frames, MSB first.
module spi_reg_controller
    import spi_reg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              copi,
    input  logic              cipo,
    output logic              ncs
);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]       rx_q, rx_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [4:0]              bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic                    copi_q, copi_d;
    logic                    ncs_q, ncs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tick;

    // The divider is held at zero in idle so every phase starts on a fresh CLK_DIV count.
    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q != StIdle),
        .clr_i (state_q == StIdle),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d = {rw, addr, wdata};
                    copi_d  = rw;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: only the data byte is captured from the peripheral.
                        if (bit_q >= 5'd8) begin
                            rx_d = {rx_q[DATA_W-2:0], cipo};
                        end
                    end else begin
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                        copi_d  = shift_q[FRAME_BITS-2];
                        if (bit_q == 5'd15) begin
                            copi_d  = 1'b0;
                            state_d = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    ncs_d   = 1'b1;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign copi  = copi_q;
    assign ncs   = ncs_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: several CLK_DIV instances, a peripheral monitor and a frame scoreboard.
module tb_spi_reg_controller;

    localparam int NI = 5;
    localparam int unsigned DIVS [NI] = '{4, 1, 2, 7, 255};

    logic       clk = 1'b0;
    logic       rst;
    logic       start [NI];
    logic       rw    [NI];
    logic [6:0] addr  [NI];
    logic [7:0] wdata [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic [7:0] rdata [NI];
    logic       sclk  [NI];
    logic       copi  [NI];
    logic       cipo  [NI];
    logic       ncs   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_reg_controller #(
            .CLK_DIV(DIVS[g])
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start[g]),
            .rw   (rw[g]),
            .addr (addr[g]),
            .wdata(wdata[g]),
            .busy (busy[g]),
            .done (done[g]),
            .rdata(rdata[g]),
            .sclk (sclk[g]),
            .copi (copi[g]),
            .cipo (cipo[g]),
            .ncs  (ncs[g])
        );
    end

    typedef struct {
        logic [15:0] bits;
        int          rises;
        int          low;
        int          gap;
    } obs_t;

    obs_t        obs_q [$];
    logic [15:0] exp_q [$];
    int          sel = 0;
    logic [7:0]  pdata = 8'h00;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          last_gap = 0;

    // Peripheral model: samples the selected instance half a clock away from the active edge.
    initial begin
        logic [15:0] bits;
        logic        p_sclk;
        logic        p_ncs;
        bits   = '0;
        p_sclk = 1'b0;
        p_ncs  = 1'b1;
        for (int i = 0; i < NI; i++) cipo[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (done[sel] === 1'b1) done_cnt++;
            if (p_ncs && ncs[sel] === 1'b0) begin
                rise_cnt = 0;
                fall_cnt = 0;
                bits     = '0;
                low_cnt  = 0;
                last_gap = high_cnt;
            end
            if (ncs[sel] === 1'b0) begin
                low_cnt++;
                high_cnt = 0;
            end else begin
                high_cnt++;
            end
            if (ncs[sel] === 1'b0 && !p_sclk && sclk[sel] === 1'b1) begin
                bits = {bits[14:0], copi[sel]};
                rise_cnt++;
            end
            if (ncs[sel] === 1'b0 && p_sclk && sclk[sel] === 1'b0) begin
                fall_cnt++;
                cipo[sel] = (fall_cnt >= 8 && fall_cnt < 16) ? pdata[15 - fall_cnt] : 1'b0;
            end
            if (!p_ncs && ncs[sel] === 1'b1) begin
                obs_q.push_back('{bits, rise_cnt, low_cnt, last_gap});
                cipo[sel] = 1'b0;
            end
            p_sclk = (sclk[sel] === 1'b1);
            p_ncs  = (ncs[sel] !== 1'b0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] d);
        rw[sel]    = r;
        addr[sel]  = a;
        wdata[sel] = d;
        start[sel] = 1'b1;
        exp_q.push_back({r, a, d});
        step();
        start[sel] = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 1;
        while (done[sel] !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy[sel] !== 1'b0 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (ncs[0] !== 1'b1) begin bad++; $display("FAIL reset_ncs: got %b want 1", ncs[0]); end
        total++; if (sclk[0] !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk[0]); end
        total++; if (copi[0] !== 1'b0) begin bad++; $display("FAIL reset_copi: got %b want 0", copi[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        total++; if (done[0] !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done[0]); end
        total++; if (rdata[0] !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata[0]); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        int n;
        int dc;
        obs_t o;
        logic [15:0] e;
        sel   = 0;
        pdata = 8'h5A;
        launch(1'b1, 7'h04, 8'h80);
        wait_done(400, n);
        total++; if (done[sel] !== 1'b1 || n != 137) begin
            bad++; $display("FAIL write_done_latency: got %0d want 137", n);
        end
        dc = done_cnt;
        total++; if (rdata[sel] !== 8'h5A) begin bad++; $display("FAIL write_rdata: got %h want 5a", rdata[sel]); end
        step();
        total++; if (done[sel] !== 1'b0) begin bad++; $display("FAIL write_done_pulse: got %b want 0", done[sel]); end
        step();
        step();
        total++; if (busy[sel] !== 1'b1) begin bad++; $display("FAIL write_busy_gap: got %b want 1", busy[sel]); end
        step();
        total++; if (busy[sel] !== 1'b0) begin bad++; $display("FAIL write_busy_fall: got %b want 0", busy[sel]); end
        total++; if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL write_frame_count: got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++; if (o.bits !== e) begin bad++; $display("FAIL write_bits: got %h want %h", o.bits, e); end
            total++; if (o.rises != 16) begin bad++; $display("FAIL write_rises: got %0d want 16", o.rises); end
            total++; if (o.low != 136) begin bad++; $display("FAIL write_ncs_low: got %0d want 136", o.low); end
        end
        total++; if (done_cnt != dc) begin bad++; $display("FAIL write_extra_done: got %0d want %0d", done_cnt, dc); end
    endtask

    task automatic test_read();
        int n;
        obs_t o;
        logic [15:0] e;
        sel   = 0;
        pdata = 8'hA5;
        launch(1'b0, 7'h02, 8'h3C);
        wait_done(400, n);
        total++; if (done[sel] !== 1'b1) begin bad++; $display("FAIL read_done: got %b want 1", done[sel]); end
        total++; if (rdata[sel] !== 8'hA5) begin bad++; $display("FAIL read_rdata: got %h want a5", rdata[sel]); end
        pdata = 8'h00;
        repeat (20) step();
        total++; if (rdata[sel] !== 8'hA5) begin bad++; $display("FAIL read_rdata_hold: got %h want a5", rdata[sel]); end
        total++; if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL read_frame_count: got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++; if (o.bits !== e) begin bad++; $display("FAIL read_bits: got %h want %h", o.bits, e); end
        end
        wait_idle(50);
    endtask

    task automatic test_busy_ignore();
        int ndone;
        obs_t o;
        logic [15:0] e;
        sel   = 0;
        ndone = 0;
        for (int c = 0; c < 420; c++) begin
            start[sel] = (c == 10 || c == 50 || c == 100);
            if (c == 10) begin
                rw[sel]    = 1'b1;
                addr[sel]  = 7'h01;
                wdata[sel] = 8'hC3;
                exp_q.push_back({1'b1, 7'h01, 8'hC3});
            end
            if (c == 60) addr[sel] = 7'h7F;
            if (done[sel] === 1'b1) ndone++;
            step();
        end
        start[sel] = 1'b0;
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        total++; if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL ignore_frame_count: got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++; if (o.bits !== e) begin bad++; $display("FAIL ignore_bits: got %h want %h", o.bits, e); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_rst_mid();
        int n;
        int dc;
        obs_t o;
        logic [15:0] e;
        sel   = 0;
        pdata = 8'h00;
        launch(1'b1, 7'h03, 8'h11);
        n = 0;
        while (rise_cnt != 7 && n < 200) begin
            step();
            n++;
        end
        total++; if (rise_cnt != 7) begin bad++; $display("FAIL rst_reach_rise7: got %0d want 7", rise_cnt); end
        dc  = done_cnt;
        rst = 1'b1;
        #1;
        total++; if (ncs[sel] !== 1'b1) begin bad++; $display("FAIL rst_mid_ncs: got %b want 1", ncs[sel]); end
        total++; if (sclk[sel] !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk: got %b want 0", sclk[sel]); end
        total++; if (copi[sel] !== 1'b0) begin bad++; $display("FAIL rst_mid_copi: got %b want 0", copi[sel]); end
        total++; if (busy[sel] !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy[sel]); end
        step();
        step();
        step();
        rst = 1'b0;
        step();
        total++; if (done_cnt != dc) begin bad++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_cnt, dc); end
        obs_q.delete();
        exp_q.delete();
        launch(1'b1, 7'h04, 8'h7E);
        wait_done(400, n);
        total++; if (done[sel] !== 1'b1 || n != 137) begin
            bad++; $display("FAIL rst_fresh_latency: got %0d want 137", n);
        end
        total++; if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL rst_fresh_count: got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++; if (o.bits !== e) begin bad++; $display("FAIL rst_fresh_bits: got %h want %h", o.bits, e); end
            total++; if (o.rises != 16) begin bad++; $display("FAIL rst_fresh_rises: got %0d want 16", o.rises); end
        end
        wait_idle(50);
    endtask

    task automatic test_back_to_back();
        int falls;
        int n;
        int dc;
        logic pn;
        obs_t o;
        logic [15:0] e;
        sel        = 1;
        dc         = done_cnt;
        rw[sel]    = 1'b1;
        addr[sel]  = 7'h00;
        wdata[sel] = 8'hF0;
        start[sel] = 1'b1;
        falls      = 0;
        n          = 0;
        pn         = 1'b1;
        while (falls < 3 && n < 300) begin
            step();
            n++;
            if (pn && ncs[sel] === 1'b0) begin
                falls++;
                exp_q.push_back({1'b1, 7'h00, 8'hF0});
            end
            pn = (ncs[sel] !== 1'b0);
        end
        start[sel] = 1'b0;
        wait_idle(100);
        step();
        total++; if (obs_q.size() != 3 || exp_q.size() != 3) begin
            bad++; $display("FAIL b2b_frame_count: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                total++; if (o.bits !== e) begin bad++; $display("FAIL b2b_bits: got %h want %h", o.bits, e); end
                total++; if (o.low != 34) begin bad++; $display("FAIL b2b_ncs_low: got %0d want 34", o.low); end
                if (i > 0) begin
                    total++; if (o.gap != 2) begin bad++; $display("FAIL b2b_gap: got %0d want 2", o.gap); end
                end
            end
        end
        total++; if (done_cnt - dc != 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - dc); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_sweep();
        int n;
        int want;
        logic [6:0] a;
        logic [7:0] d;
        obs_t o;
        for (int s = 1; s < NI; s++) begin
            sel  = s;
            a    = 7'($urandom_range(0, 127));
            d    = 8'($urandom_range(0, 255));
            want = 34 * int'(DIVS[s]);
            launch(1'b1, a, d);
            wait_done(want + 20, n);
            total++; if (done[sel] !== 1'b1 || n != want + 1) begin
                bad++; $display("FAIL sweep_latency div=%0d: got %0d want %0d", DIVS[s], n, want + 1);
            end
            total++; if (obs_q.size() != 1) begin
                bad++; $display("FAIL sweep_count div=%0d: got %0d want 1", DIVS[s], obs_q.size());
            end else begin
                o = obs_q.pop_front();
                total++; if (o.bits[15] !== 1'b1 || o.bits[14:8] !== a || o.bits[7:0] !== d) begin
                    bad++; $display("FAIL sweep_decode div=%0d: got %h want %h", DIVS[s], o.bits, {1'b1, a, d});
                end
                total++; if (o.low != want) begin
                    bad++; $display("FAIL sweep_ncs_low div=%0d: got %0d want %0d", DIVS[s], o.low, want);
                end
            end
            exp_q.delete();
            wait_idle(600);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            rw[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_rst_mid();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
